// File: rtl/beagleg_pkg.sv
// Shared defaults and state encoding for the record dispatch path.
package beagleg_pkg;

    localparam int WORD_SIZE_DEFAULT    = 8;
    localparam int RECORD_WORDS_DEFAULT = 16;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } disp_state_e;

endpackage

// File: rtl/record_dispatcher.sv
// Moves whole records from a show-ahead fifo into a one-deep output register
// with valid/ready handshake, plus accepted-record count and underrun flag.
module record_dispatcher
    import beagleg_pkg::*;
#(
    parameter int  WordSize       = WORD_SIZE_DEFAULT,
    parameter int  RecordWords    = RECORD_WORDS_DEFAULT,
    localparam int RecordSizeBits = WordSize * RecordWords
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      fifo_empty,
    input  logic [RecordSizeBits-1:0] fifo_data,
    output logic                      fifo_read_en,
    output logic                      rec_valid,
    output logic [RecordSizeBits-1:0] rec_data,
    input  logic                      rec_ready,
    output logic                      busy,
    output logic                      underrun,
    output logic [15:0]               rec_count,
    input  logic                      clear_stats
);

    disp_state_e               state_q, state_d;
    logic [RecordSizeBits-1:0] rec_data_q, rec_data_d;
    logic [15:0]               rec_count_q, rec_count_d;
    logic                      underrun_q, underrun_d;
    logic                      load;
    logic                      accept;

    // rst_n gates the dequeue so the fifo never advances while we are held in reset.
    always_comb begin
        accept = (state_q == HOLD) && rec_ready;
        load   = rst_n && enable && !fifo_empty
                 && ((state_q == IDLE) || ((state_q == HOLD) && rec_ready));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load) state_d = HOLD;
            HOLD:    if (accept && !load) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Statistics: clear_stats wins over a same-cycle increment or underrun set.
    always_comb begin
        rec_data_d  = load ? fifo_data : rec_data_q;
        rec_count_d = rec_count_q;
        underrun_d  = underrun_q;
        if (clear_stats) begin
            rec_count_d = 16'd0;
            underrun_d  = 1'b0;
        end else begin
            if (accept) rec_count_d = rec_count_q + 16'd1;
            if (accept && enable && fifo_empty) underrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rec_data_q  <= '0;
            rec_count_q <= 16'd0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rec_data_q  <= rec_data_d;
            rec_count_q <= rec_count_d;
            underrun_q  <= underrun_d;
        end
    end

    always_comb begin
        fifo_read_en = load;
        rec_valid    = (state_q == HOLD);
        busy         = (state_q == HOLD);
        rec_data     = rec_data_q;
        rec_count    = rec_count_q;
        underrun     = underrun_q;
    end

endmodule

// File: doc/record_dispatcher.md
RECORD_DISPATCHER -- requirements
Module: record_dispatcher

Interface
REQ-001 The module SHALL have parameter WordSize, default 8, bits per fifo word.
REQ-002 The module SHALL have parameter RecordWords, default 16, words per record (power of 2).
REQ-003 The module SHALL have localparam RecordSizeBits = WordSize*RecordWords, not overridable.
REQ-004 The module SHALL have the following ports; the clock is clk and the reset is rst_n, one clock, reset asynchronous and active-low:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  dispatch permitted while high.
- fifo_empty  in  1  fifo holds no complete record.
- fifo_data  in  RecordSizeBits  fifo head record, combinational from fifo.
- fifo_read_en  out  1  dequeue one record on this rising edge.
- rec_valid  out  1  rec_data holds a record for downstream.
- rec_data  out  RecordSizeBits  registered record.
- rec_ready  in  1  downstream accepts rec_data this cycle.
- busy  out  1  state != IDLE.
- underrun  out  1  sticky downstream-starvation flag.
- rec_count  out  16  records accepted by downstream, wrapping.
- clear_stats  in  1  synchronous clear of underrun and rec_count.

Function
REQ-005 The FSM SHALL have exactly two states: IDLE (no record held) and HOLD (record held, rec_valid=1).
REQ-006 load condition SHALL be: enable && !fifo_empty && (state==IDLE || (state==HOLD && rec_ready)).
REQ-007 fifo_read_en SHALL equal load condition combinationally; at most one pulse per cycle, never asserted while fifo_empty=1.
REQ-008 On load, rec_data SHALL capture fifo_data at the same rising edge the fifo advances; next state HOLD.
REQ-009 Latency SHALL be 1 cycle: fifo_read_en high in cycle N -> rec_valid high and rec_data valid in cycle N+1.
REQ-010 In HOLD with rec_ready=0, rec_data and rec_valid SHALL remain stable; no fifo read.
REQ-011 In HOLD with rec_ready=1 and load condition true, the next record SHALL be loaded back-to-back; state stays HOLD, rec_valid stays 1 (one record per cycle sustained).
REQ-012 In HOLD with rec_ready=1 and load condition false, next state SHALL be IDLE, rec_valid 0.
REQ-013 Deasserting enable in HOLD SHALL NOT drop the held record; it is presented until accepted, then IDLE.
REQ-014 rec_ready in IDLE SHALL be ignored; rec_count increments only on rec_valid && rec_ready.
REQ-015 rec_count SHALL wrap 16'hFFFF -> 0.
REQ-016 underrun SHALL set when rec_valid && rec_ready && enable && fifo_empty, and remain set until clear_stats or reset.
REQ-017 clear_stats SHALL take priority over same-cycle set/increment: underrun->0, rec_count->0.
REQ-018 busy SHALL be 1 exactly in HOLD.

Reset
REQ-019 On rst_n low, asynchronously: state IDLE, rec_valid 0, rec_data 0, rec_count 0, underrun 0; fifo_read_en 0 during reset.
REQ-020 Reset mid-HOLD SHALL discard the held record; no fifo read in first cycle after release unless load condition holds.

Structure
REQ-021 WordSize/RecordWords defaults and the IDLE/HOLD state enum SHALL live in shared package beagleg_pkg.
REQ-022 No sub-module; single always_ff plus combinational load logic.

Verification
REQ-023 Reset, enable=1, fifo_empty=0, head=128'hA5.., rec_ready=0 -> read_en pulse cycle 1 only, rec_valid=1 from cycle 2, rec_data=128'hA5.. held.
REQ-024 4 records queued, rec_ready=1 constant -> 4 consecutive read_en pulses, rec_valid continuous 4 cycles, rec_count=4, underrun=1 on last accept.
REQ-025 enable dropped while HOLD with rec_ready=0 -> record held; rec_ready=1 -> rec_count+1, IDLE, no further read_en.
REQ-026 rec_count preset to 16'hFFFF via 65535 accepts, one more accept -> rec_count=0.
REQ-027 clear_stats=1 same cycle as underrun-setting accept -> underrun=0, rec_count=0.
REQ-028 rst_n low mid-HOLD -> rec_valid=0 immediately (async), rec_count=0, busy=0.
